// File: rtl/branch_resolve.sv
// branch_resolve
//   Branch resolution stage sitting right after the branch comparator.
//   Decides taken/not-taken for B-type, JAL and JALR, computes the redirect
//   target, hands it to fetch over valid/ready, then holds o_flush for
//   FLUSH_CYCLES cycles.
//
//   Optional feature: define BRANCH_STATS_EN to build the conditional-branch
//   statistics counters (o_br_count / o_taken_count). Without it both ports
//   read 0 and no counter flops exist.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_valid / o_ready       instruction handshake (ready only in IDLE)
//   i_is_branch/jal/jalr    decoded kind (priority jalr > jal > branch)
//   i_funct3                branch condition code
//   i_pc, i_imm, i_rs1_data target operands
//   i_less, i_equal         comparator flags
//   o_br_unsigned           unsigned-compare select back to the comparator
//   o_redirect_valid/pc     redirect request to fetch, i_redirect_ready accepts
//   o_flush                 squash younger instructions
//   o_busy                  not IDLE
//   o_br_count/taken_count  statistics
module branch_resolve #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic            i_is_branch,
  input  logic            i_is_jal,
  input  logic            i_is_jalr,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic            i_less,
  input  logic            i_equal,
  output logic            o_br_unsigned,
  output logic            o_redirect_valid,
  input  logic            i_redirect_ready,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_flush,
  output logic            o_busy,
  output logic [31:0]     o_br_count,
  output logic [31:0]     o_taken_count
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REDIRECT = 2'd1,
    S_FLUSH    = 2'd2
  } state_e;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   redir_pc_q, redir_pc_d;
  logic [3:0]        cnt_q, cnt_d;

  // Resolution of the presented instruction (only meaningful on accept)
  logic            accept;
  logic            kind_jalr, kind_jal, kind_br;
  logic            br_legal, br_cond, taken;
  logic [XLEN-1:0] target;

  assign o_br_unsigned = i_funct3[1];
  assign o_ready       = (state_q == S_IDLE) && !i_rst;
  assign accept        = i_valid && o_ready;

  always_comb begin
    kind_jalr = i_is_jalr;
    kind_jal  = !i_is_jalr && i_is_jal;
    kind_br   = !i_is_jalr && !i_is_jal && i_is_branch;
    br_legal  = 1'b1;
    br_cond   = 1'b0;
    case (i_funct3)
      3'b000:  br_cond = i_equal;
      3'b001:  br_cond = !i_equal;
      3'b100,
      3'b110:  br_cond = i_less;
      3'b101,
      3'b111:  br_cond = !i_less;
      default: br_legal = 1'b0;
    endcase
    taken  = kind_jalr || kind_jal || (kind_br && br_legal && br_cond);
    // JALR clears bit 0 of the sum; all adds wrap modulo 2^XLEN
    target = kind_jalr ? ((i_rs1_data + i_imm) & ~{{(XLEN-1){1'b0}}, 1'b1})
                       : (i_pc + i_imm);
  end

  always_comb begin
    state_d    = state_q;
    redir_pc_d = redir_pc_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept && taken) begin
          state_d    = S_REDIRECT;
          redir_pc_d = target;
        end
      end
      S_REDIRECT: begin
        if (i_redirect_ready) begin
          if (FLUSH_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_FLUSH;
            cnt_d   = FLUSH_INIT;
          end
        end
      end
      S_FLUSH: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      redir_pc_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      redir_pc_q <= redir_pc_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_redirect_valid = (state_q == S_REDIRECT);
  assign o_redirect_pc    = redir_pc_q;
  assign o_flush          = (state_q == S_FLUSH);
  assign o_busy           = (state_q != S_IDLE);

`ifdef BRANCH_STATS_EN
  logic [31:0] br_count_q, br_count_d;
  logic [31:0] taken_count_q, taken_count_d;

  always_comb begin
    br_count_d    = br_count_q;
    taken_count_d = taken_count_q;
    if (accept && kind_br && br_legal) begin
      br_count_d = br_count_q + 32'd1;
      if (br_cond) taken_count_d = taken_count_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      br_count_q    <= '0;
      taken_count_q <= '0;
    end else begin
      br_count_q    <= br_count_d;
      taken_count_q <= taken_count_d;
    end
  end

  assign o_br_count    = br_count_q;
  assign o_taken_count = taken_count_q;
`else
  assign o_br_count    = 32'd0;
  assign o_taken_count = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;
  localparam int XLEN = 32;
  localparam int FC   = 2;

  logic            clk = 1'b0;
  logic            rst, valid, ready;
  logic            is_br, is_jal, is_jalr;
  logic [2:0]      f3;
  logic [XLEN-1:0] pc, imm, rs1;
  logic            less, equal, br_uns, rv, rrdy, flush, busy;
  logic [XLEN-1:0] rpc;
  logic [31:0]     brc, tkc;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  branch_resolve #(.XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready),
    .i_is_branch(is_br), .i_is_jal(is_jal), .i_is_jalr(is_jalr),
    .i_funct3(f3), .i_pc(pc), .i_imm(imm), .i_rs1_data(rs1),
    .i_less(less), .i_equal(equal), .o_br_unsigned(br_uns),
    .o_redirect_valid(rv), .i_redirect_ready(rrdy), .o_redirect_pc(rpc),
    .o_flush(flush), .o_busy(busy), .o_br_count(brc), .o_taken_count(tkc)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // pending redirect target + number of flush cycles still owed
  bit          m_pend;
  logic [31:0] m_pc;
  int          m_flush_left;
  logic [31:0] m_br, m_tk;

  always @(posedge clk) begin
    if (rst) begin
      m_pend = 0; m_pc = 0; m_flush_left = 0; m_br = 0; m_tk = 0;
    end else if (m_pend) begin
      if (rrdy) begin m_pend = 0; m_flush_left = FC; end
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (valid) begin
      bit t; bit legal; logic [31:0] tgt;
      t = 0; legal = 1; tgt = pc + imm;
      if (is_jalr) begin t = 1; tgt = (rs1 + imm) & 32'hFFFF_FFFE; end
      else if (is_jal) t = 1;
      else if (is_br) begin
        case (f3)
          3'd0: t = equal;  3'd1: t = !equal;
          3'd4: t = less;   3'd5: t = !less;
          3'd6: t = less;   3'd7: t = !less;
          default: legal = 0;
        endcase
`ifdef BRANCH_STATS_EN
        if (legal) begin m_br = m_br + 1; if (t) m_tk = m_tk + 1; end
`endif
      end
      if (t) begin m_pend = 1; m_pc = tgt; end
    end
  end

  // compare process: every negedge
  always @(negedge clk) begin
    chk("ready", ready, (!m_pend && m_flush_left == 0 && !rst));
    chk("redirect_valid", rv, m_pend);
    chk("flush", flush, m_flush_left > 0);
    chk("busy", busy, m_pend || m_flush_left > 0);
    if (m_pend) chk("redirect_pc", rpc, m_pc);
    chk("br_count", brc, m_br);
    chk("taken_count", tkc, m_tk);
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!ready && k < 30) begin step(); k++; end
    if (!ready) begin
      checks++;
      $display("FAIL wait_idle: o_ready stuck at 0, expected 1");
    end
  endtask

  // present one instruction for one accept edge (caller ensures o_ready)
  task automatic issue(input bit b, input bit j, input bit jr, input logic [2:0] fn,
                       input logic [31:0] p, input logic [31:0] im, input logic [31:0] r,
                       input bit ls, input bit eq);
    valid = 1; is_br = b; is_jal = j; is_jalr = jr; f3 = fn;
    pc = p; imm = im; rs1 = r; less = ls; equal = eq;
    step();
    valid = 0; is_br = 0; is_jal = 0; is_jalr = 0;
  endtask

  initial begin
    rst = 1; valid = 0; is_br = 0; is_jal = 0; is_jalr = 0; f3 = 0;
    pc = 0; imm = 0; rs1 = 0; less = 0; equal = 0; rrdy = 1;
    step(2);
    chk("rst_ready", ready, 1'b0);
    chk("rst_rpc", rpc, 32'h0);
    rst = 0;
    step();

    // 1. BEQ taken, fetch ready immediately
    issue(1, 0, 0, 3'b000, 32'h100, 32'h20, 0, 0, 1);
    chk("t1_valid", rv, 1'b1);
    chk("t1_pc", rpc, 32'h120);
    step(); chk("t1_flush1", flush, 1'b1);
    step(); chk("t1_flush2", flush, 1'b1);
    step(); chk("t1_flush_end", flush, 1'b0); chk("t1_ready", ready, 1'b1);

    // 2. BGEU with less=1: not taken
    f3 = 3'b111; #1; chk("t2_unsigned", br_uns, 1'b1);
    issue(1, 0, 0, 3'b111, 32'h300, 32'h40, 0, 1, 0);
    chk("t2_noredir", rv, 1'b0); chk("t2_ready", ready, 1'b1);
    step(); chk("t2_noflush", flush, 1'b0);
    f3 = 3'b000; #1; chk("t2_signed_sel", br_uns, 1'b0);

    // 3. JALR clears bit 0; JAL wraps
    wait_idle();
    issue(0, 0, 1, 3'b000, 32'h500, 32'h4, 32'h1003, 0, 0);
    chk("t3_jalr_pc", rpc, 32'h1006);
    wait_idle();
    issue(0, 1, 0, 3'b000, 32'hFFFF_FFF0, 32'h20, 0, 0, 0);
    chk("t3_jal_wrap", rpc, 32'h10);
    // kind priority: jalr wins over jal/branch flags
    wait_idle();
    issue(1, 1, 1, 3'b010, 32'h800, 32'h10, 32'h2000, 0, 0);
    chk("t3_prio", rpc, 32'h2010);

    // 4. backpressure
    wait_idle();
    rrdy = 0;
    issue(1, 0, 0, 3'b001, 32'h200, 32'hFFFF_FFF8, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t4_hold_valid", rv, 1'b1); chk("t4_hold_pc", rpc, 32'h1F8);
      chk("t4_not_ready", ready, 1'b0); chk("t4_no_flush", flush, 1'b0);
      step();
    end
    rrdy = 1;
    step(); chk("t4_flush1", flush, 1'b1);
    step(); chk("t4_flush2", flush, 1'b1);
    step(); chk("t4_done", ready, 1'b1);

    // 5. reset during REDIRECT, then during FLUSH
    rrdy = 0;
    issue(0, 1, 0, 3'b000, 32'h40, 32'h8, 0, 0, 0);
    rst = 1; step();
    chk("t5a_rv", rv, 1'b0); chk("t5a_rpc", rpc, 32'h0); chk("t5a_busy", busy, 1'b0);
    rst = 0; rrdy = 1;
    for (int i = 0; i < 3; i++) begin chk("t5a_noflush", flush, 1'b0); step(); end
    issue(0, 1, 0, 3'b000, 32'h40, 32'h8, 0, 0, 0);
    step(); chk("t5b_in_flush", flush, 1'b1);
    rst = 1; step();
    chk("t5b_flush", flush, 1'b0); chk("t5b_busy", busy, 1'b0); chk("t5b_rpc", rpc, 32'h0);
    rst = 0;
    step(); chk("t5b_noflush", flush, 1'b0); chk("t5b_ready", ready, 1'b1);

    // 6. statistics: 5 legal branches (3 taken) + 1 illegal funct3
    wait_idle(); issue(1, 0, 0, 3'b000, 32'h0, 32'h4, 0, 0, 1);   // BEQ taken
    wait_idle(); issue(1, 0, 0, 3'b001, 32'h0, 32'h4, 0, 0, 1);   // BNE not
    wait_idle(); issue(1, 0, 0, 3'b100, 32'h0, 32'h4, 0, 1, 0);   // BLT taken
    wait_idle(); issue(1, 0, 0, 3'b110, 32'h0, 32'h4, 0, 0, 0);   // BLTU not
    wait_idle(); issue(1, 0, 0, 3'b010, 32'h0, 32'h4, 0, 1, 1);   // illegal
    wait_idle(); issue(1, 0, 0, 3'b101, 32'h0, 32'h4, 0, 0, 0);   // BGE taken
    wait_idle();
`ifdef BRANCH_STATS_EN
    chk("t6_br_count", brc, 32'd5);
    chk("t6_taken_count", tkc, 32'd3);
`else
    chk("t6_br_count", brc, 32'd0);
    chk("t6_taken_count", tkc, 32'd0);
`endif
    step(2);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
